// File: rtl/mem_line_sched.sv
// Main-memory line scheduler: pops ring requests, consults the line directory and runs
// read/write bursts, grant-only replies or retry pushes toward the resend queue.
module mem_line_sched #(
  parameter int unsigned MBITS           = 24,
  parameter int unsigned LINE_LOG        = 3,
  parameter logic [3:0]  SLOT_ADDRESS    = 4'h1,
  parameter logic [3:0]  SLOT_GRANT_EXCL = 4'h6
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ma_empty_i,
  input  logic [31:0]               ma_addr_i,
  input  logic [3:0]                ma_dest_i,
  output logic                      ma_rd_o,
  input  logic                      md_empty_i,
  output logic                      md_rd_o,
  output logic [MBITS-LINE_LOG-1:0] dir_addr_o,
  input  logic [1:0]                dir_rdata_i,
  output logic                      dir_we_o,
  output logic [1:0]                dir_wdata_o,
  output logic [MBITS-1:0]          mem_addr_o,
  output logic                      mem_re_o,
  output logic                      mem_we_o,
  output logic [3:0]                rd_dest_o,
  output logic                      rq_wr_o,
  output logic [39:0]               rq_din_o,
  input  logic                      rq_full_i,
  output logic                      err_range_o
);
  localparam int unsigned LW = MBITS - LINE_LOG;

  typedef enum logic [1:0] {IDLE, LOOKUP, READ_BURST, WRITE_BURST} state_e;
  typedef enum logic [1:0] {DIR_CLEAN = 2'd0, DIR_WAITING = 2'd1, DIR_MODIFIED = 2'd2} dir_e;

  state_e              state_q, state_d;
  logic [LINE_LOG-1:0] beat_q, beat_d;
  logic [3:0]          rd_dest_q, rd_dest_d;
  logic                lk_stall_q, lk_stall_d;

  logic [LW-1:0] line;
  logic          is_read, is_retry, is_grant, is_excl;
  logic          possible, out_of_range, beat_last;

  // The FIFO head stays put until the final pop, so the line index is taken straight from it.
  assign line         = ma_addr_i[LW-1:0];
  assign is_retry     = ma_addr_i[31];
  assign is_grant     = ma_addr_i[30];
  assign is_excl      = ma_addr_i[29];
  assign is_read      = ma_addr_i[28];
  assign out_of_range = (ma_addr_i[27:0] >> LW) != 28'd0;
  assign possible     = (dir_rdata_i == DIR_CLEAN) || ((dir_rdata_i == DIR_WAITING) && is_retry);
  assign beat_last    = (beat_q == '1);
  assign rd_dest_o    = rd_dest_q;

  // Strobes are decoded from the registered state because they must react to FIFO/RAM
  // status in the same cycle; sequencing state lives entirely in the _q registers.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    lk_stall_d  = 1'b0;
    rd_dest_d   = '0;
    ma_rd_o     = 1'b0;
    md_rd_o     = 1'b0;
    dir_we_o    = 1'b0;
    dir_wdata_o = DIR_CLEAN;
    mem_addr_o  = '0;
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    rq_wr_o     = 1'b0;
    rq_din_o    = '0;
    err_range_o = 1'b0;
    dir_addr_o  = line;
    unique case (state_q)
      IDLE: begin
        if (!ma_empty_i) state_d = LOOKUP;
      end
      LOOKUP: begin
        // Pulse only on the first LOOKUP cycle, even if the reply later stalls.
        err_range_o = out_of_range & ~lk_stall_q;
        if (!is_read) begin
          dir_we_o    = 1'b1;
          dir_wdata_o = is_excl ? DIR_WAITING : DIR_CLEAN;
          beat_d      = '0;
          state_d     = WRITE_BURST;
        end else if (possible && !is_grant) begin
          dir_we_o    = 1'b1;
          dir_wdata_o = is_excl ? DIR_MODIFIED : DIR_CLEAN;
          beat_d      = '0;
          state_d     = READ_BURST;
        end else if (rq_full_i) begin
          lk_stall_d = 1'b1;
        end else begin
          rq_wr_o = 1'b1;
          ma_rd_o = 1'b1;
          state_d = IDLE;
          if (possible) begin
            dir_we_o    = 1'b1;
            dir_wdata_o = is_excl ? DIR_MODIFIED : DIR_CLEAN;
            rq_din_o    = {ma_dest_i, SLOT_GRANT_EXCL, 4'h0, ma_addr_i[27:0]};
          end else begin
            rq_din_o = {ma_dest_i, SLOT_ADDRESS, 2'b10, ma_addr_i[29:0]};
          end
        end
      end
      READ_BURST: begin
        mem_re_o   = 1'b1;
        mem_addr_o = {line, beat_q};
        rd_dest_d  = ma_dest_i;
        beat_d     = beat_q + 1'b1;
        if (beat_last) begin
          ma_rd_o = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE_BURST: begin
        mem_addr_o = {line, beat_q};
        if (!md_empty_i) begin
          md_rd_o  = 1'b1;
          mem_we_o = 1'b1;
          beat_d   = beat_q + 1'b1;
          if (beat_last) begin
            ma_rd_o = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      rd_dest_q  <= '0;
      lk_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rd_dest_q  <= rd_dest_d;
      lk_stall_q <= lk_stall_d;
    end
  end
endmodule

// File: tb/tb_mem_line_sched.sv
// Randomized bench for mem_line_sched: FIFO/RAM environment plus a per-transaction
// reference model of directory outcomes, bursts and resend-queue replies.
module tb_mem_line_sched;
  localparam int unsigned MBITS = 24;
  localparam int unsigned LW    = MBITS - 3;
  localparam logic [3:0] SLOT_ADDR = 4'h1;
  localparam logic [3:0] SLOT_GNT  = 4'h6;
  localparam logic [1:0] CLEAN = 2'd0, WAITING = 2'd1, MODIFIED = 2'd2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             ma_empty_i;
  logic [31:0]      ma_addr_i;
  logic [3:0]       ma_dest_i;
  logic             ma_rd_o;
  logic             md_empty_i;
  logic             md_rd_o;
  logic [LW-1:0]    dir_addr_o;
  logic [1:0]       dir_rdata_i;
  logic             dir_we_o;
  logic [1:0]       dir_wdata_o;
  logic [MBITS-1:0] mem_addr_o;
  logic             mem_re_o;
  logic             mem_we_o;
  logic [3:0]       rd_dest_o;
  logic             rq_wr_o;
  logic [39:0]      rq_din_o;
  logic             rq_full_i;
  logic             err_range_o;

  always #5 clk_i = ~clk_i;

  mem_line_sched #(
    .MBITS(MBITS), .LINE_LOG(3), .SLOT_ADDRESS(SLOT_ADDR), .SLOT_GRANT_EXCL(SLOT_GNT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .ma_empty_i(ma_empty_i), .ma_addr_i(ma_addr_i), .ma_dest_i(ma_dest_i), .ma_rd_o(ma_rd_o),
    .md_empty_i(md_empty_i), .md_rd_o(md_rd_o),
    .dir_addr_o(dir_addr_o), .dir_rdata_i(dir_rdata_i), .dir_we_o(dir_we_o), .dir_wdata_o(dir_wdata_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .rd_dest_o(rd_dest_o),
    .rq_wr_o(rq_wr_o), .rq_din_o(rq_din_o), .rq_full_i(rq_full_i), .err_range_o(err_range_o)
  );

  typedef struct packed {logic [31:0] addr; logic [3:0] dest;} req_t;

  int unsigned n_chk = 0, n_bad = 0;
  req_t        aq[$];
  logic [31:0] mdq[$], mdl_md[$];
  logic [1:0]  dir_ram[int], mdl_dir[int];
  logic [31:0] mem[int];
  logic [1:0]  dir_next = 2'd0;
  int unsigned full_hold = 0, full_pct = 0, gap_pct = 0, cyc = 0;
  int unsigned lat_mark = 0, lat_re = 0;
  logic        prev_re = 1'b0;
  logic [3:0]  prev_dest = 4'h0;

  logic [MBITS-1:0] ob_re[$], ob_wa[$];
  logic [31:0]      ob_wd[$];
  logic [39:0]      ob_rq[$];
  logic [LW-1:0]    ob_da[$];
  logic [1:0]       ob_dv[$];
  int unsigned      ob_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] env_dir(input int l);
    return dir_ram.exists(l) ? dir_ram[l] : CLEAN;
  endfunction

  function automatic logic [1:0] ref_dir(input int l);
    return mdl_dir.exists(l) ? mdl_dir[l] : CLEAN;
  endfunction

  task automatic set_dir(input int l, input logic [1:0] v);
    dir_ram[l] = v;
    mdl_dir[l] = v;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] d);
    req_t r;
    r.addr = a;
    r.dest = d;
    aq.push_back(r);
  endtask

  task automatic push_md(input logic [31:0] w);
    mdq.push_back(w);
    mdl_md.push_back(w);
  endtask

  task automatic clear_obs();
    ob_re.delete(); ob_wa.delete(); ob_wd.delete();
    ob_rq.delete(); ob_da.delete(); ob_dv.delete();
    ob_err = 0;
  endtask

  // Reference outcome of one request, judged when the DUT retires it with ma_rd.
  task automatic judge(input req_t r);
    int          line, n_re, n_we;
    logic [1:0]  d, dv;
    logic [39:0] rq;
    bit          ok, has_rq, has_dir;
    logic [31:0] w;
    line = int'(r.addr[LW-1:0]);
    d = ref_dir(line);
    n_re = 0; n_we = 0; has_rq = 0; has_dir = 0; dv = CLEAN; rq = '0;
    if (r.addr[28]) begin
      ok = (d == CLEAN) || (d == WAITING && r.addr[31]);
      if (ok) begin
        has_dir = 1;
        dv = r.addr[29] ? MODIFIED : CLEAN;
      end
      if (ok && !r.addr[30]) n_re = 8;
      else if (ok) begin
        has_rq = 1;
        rq = {r.dest, SLOT_GNT, 4'h0, r.addr[27:0]};
      end else begin
        has_rq = 1;
        rq = {r.dest, SLOT_ADDR, 32'h8000_0000 | (r.addr & 32'h3FFF_FFFF)};
      end
    end else begin
      has_dir = 1;
      dv = r.addr[29] ? WAITING : CLEAN;
      n_we = 8;
    end
    check("err_range", ob_err, (r.addr[27:0] >= (28'd1 << LW)) ? 1 : 0);
    check("re_count", ob_re.size(), n_re);
    for (int i = 0; i < n_re && i < ob_re.size(); i++) check("re_addr", ob_re[i], line * 8 + i);
    check("we_count", ob_wa.size(), n_we);
    for (int i = 0; i < n_we; i++) begin
      w = (mdl_md.size() != 0) ? mdl_md.pop_front() : 32'hDEAD_BEEF;
      if (i < ob_wa.size()) begin
        check("we_addr", ob_wa[i], line * 8 + i);
        check("we_data", ob_wd[i], w);
      end
    end
    check("rq_count", ob_rq.size(), has_rq);
    if (has_rq && ob_rq.size() != 0) check("rq_din", ob_rq[0], rq);
    check("dir_count", ob_dv.size(), has_dir);
    if (has_dir && ob_dv.size() != 0) begin
      check("dir_addr", ob_da[0], line);
      check("dir_val", ob_dv[0], dv);
      mdl_dir[line] = dv;
    end
    clear_obs();
  endtask

  // Negedge: observe this cycle's outputs and apply the effects they take at the next posedge.
  task automatic sample();
    req_t r;
    check("rd_dest", rd_dest_o, prev_re ? prev_dest : 4'h0);
    if (mem_re_o && !prev_re && lat_re == 0) lat_re = cyc;
    prev_re = mem_re_o;
    prev_dest = ma_dest_i;
    if (md_rd_o) check("md_rd_gate", md_empty_i, 0);
    if (rq_wr_o) check("rq_wr_gate", rq_full_i, 0);
    if (ma_rd_o) check("ma_rd_gate", ma_empty_i, 0);
    if (err_range_o) ob_err++;
    if (mem_re_o) ob_re.push_back(mem_addr_o);
    if (mem_we_o) begin
      ob_wa.push_back(mem_addr_o);
      ob_wd.push_back(mdq.size() != 0 ? mdq[0] : 32'hDEAD_BEEF);
      mem[int'(mem_addr_o)] = mdq.size() != 0 ? mdq[0] : 32'hDEAD_BEEF;
    end
    if (md_rd_o && mdq.size() != 0) void'(mdq.pop_front());
    if (rq_wr_o) ob_rq.push_back(rq_din_o);
    dir_next = env_dir(int'(dir_addr_o));
    if (dir_we_o) begin
      ob_da.push_back(dir_addr_o);
      ob_dv.push_back(dir_wdata_o);
      dir_ram[int'(dir_addr_o)] = dir_wdata_o;
    end
    if (ma_rd_o && aq.size() != 0) begin
      r = aq.pop_front();
      judge(r);
    end
  endtask

  task automatic drive();
    cyc++;
    if (aq.size() != 0 && ma_empty_i) lat_mark = cyc;
    ma_empty_i = (aq.size() == 0);
    if (aq.size() != 0) {ma_addr_i, ma_dest_i} = aq[0];
    md_empty_i = (mdq.size() == 0) || ($urandom_range(99) < gap_pct);
    rq_full_i = (full_hold != 0) || ($urandom_range(99) < full_pct);
    if (full_hold != 0) full_hold--;
    dir_rdata_i = dir_next;
  endtask

  task automatic step();
    @(negedge clk_i);
    sample();
    @(posedge clk_i);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int unsigned budget);
    int unsigned n = 0;
    while (aq.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", aq.size(), 0);
    step();
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    logic [31:0] a;
    rst_ni = 1'b0; ma_empty_i = 1'b1; ma_addr_i = '0; ma_dest_i = '0;
    md_empty_i = 1'b1; dir_rdata_i = '0; rq_full_i = 1'b0;
    #1;
    check("rst_strobes", {ma_rd_o, md_rd_o, dir_we_o, mem_re_o, mem_we_o, rq_wr_o, err_range_o}, 0);
    check("rst_rd_dest", rd_dest_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Plain read on a clean line, with first-beat latency
    set_dir(5, CLEAN);
    push(32'h1000_0005, 4'd3);
    lat_re = 0;
    run_until_idle(100);
    check("latency", lat_re - lat_mark, 2);
    check("dir5_clean", env_dir(5), CLEAN);

    // Modified line bounces to the resend queue; a retry on WAITING bursts
    set_dir(5, MODIFIED);
    push(32'h1000_0005, 4'd3);
    run_until_idle(100);
    check("dir5_kept", env_dir(5), MODIFIED);
    set_dir(5, WAITING);
    push(32'h9000_0005, 4'd3);
    run_until_idle(100);

    // Grant-only reply while the resend queue is full for several cycles
    set_dir(9, CLEAN);
    full_hold = 6;
    push(32'h7000_0009, 4'd7);
    run_until_idle(100);
    check("dir9_mod", env_dir(9), MODIFIED);

    // Write burst with write-data bubbles
    gap_pct = 50;
    for (int i = 0; i < 8; i++) push_md(i);
    set_dir(2, CLEAN);
    push(32'h2000_0002, 4'd5);
    run_until_idle(200);
    for (int i = 0; i < 8; i++) check("mem_line2", mem.exists(16 + i) ? mem[16 + i] : 32'hFFFF_FFFF, i);
    check("md_drained", mdq.size(), 0);
    check("dir2_wait", env_dir(2), WAITING);

    // Reset in the middle of a read burst
    gap_pct = 0;
    set_dir(4, CLEAN);
    push(32'h1000_0004, 4'd6);
    n = 0;
    while (ob_re.size() < 4 && n < 50) begin
      step();
      n++;
    end
    check("rst_reach_beat4", ob_re.size(), 4);
    rst_ni = 1'b0;
    #1;
    check("midrst_strobes", {ma_rd_o, md_rd_o, dir_we_o, mem_re_o, mem_we_o, rq_wr_o, err_range_o}, 0);
    check("midrst_rd_dest", rd_dest_o, 0);
    check("midrst_mem_addr", mem_addr_o, 0);
    clear_obs();
    prev_re = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    run_until_idle(100);

    // Out-of-range address serviced at its truncated line index
    set_dir(0, CLEAN);
    push(32'h1080_0000, 4'd2);
    run_until_idle(100);

    // Randomized traffic
    for (int l = 0; l < 8; l++) set_dir(l, 2'($urandom_range(2)));
    full_pct = 30;
    gap_pct = 30;
    for (int i = 0; i < 120; i++) begin
      a = $urandom;
      a[27:0] = 28'($urandom_range(7));
      if ($urandom_range(9) == 0) a[27:21] = 7'($urandom_range(127, 1));
      if (!a[28]) for (int k = 0; k < 8; k++) push_md($urandom);
      push(a, 4'($urandom_range(15, 1)));
    end
    run_until_idle(6000);
    for (int l = 0; l < 8; l++) check("dir_final", env_dir(l), ref_dir(l));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
